// File: rtl/a2d_sched.sv
// a2d_sched: schedules A2D conversions for three IR emitter pairs plus battery monitor.
module a2d_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        batt_req,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [11:0] ir_in_lft,
  output logic [11:0] ir_in_rht,
  output logic [11:0] ir_mid_lft,
  output logic [11:0] ir_mid_rht,
  output logic [11:0] ir_out_lft,
  output logic [11:0] ir_out_rht,
  output logic [11:0] batt_res,
  output logic        batt_gnt,
  output logic        sweep_done
);

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] SETTLE_LAST = '1;
  localparam logic [1:0] PAIR_IN  = 2'd0;
  localparam logic [1:0] PAIR_OUT = 2'd2;
  localparam logic [2:0] BATT_CH  = 3'd6;

  typedef enum logic [2:0] {
    IDLE, SETTLE, CNV_A, WAIT_A, CNV_B, WAIT_B, BATT_CNV, BATT_WAIT
  } state_t;

  state_t           state, state_d;
  logic [1:0]       pair, pair_d;
  logic             resume, resume_d;
  logic             strt_d, done_d;
  logic [2:0]       chnnl_d;
  logic [2:0]       en_d;
  logic             lat_a, lat_b, lat_batt;
  logic [CNT_W-1:0] settle_cnt;

  // Right-hand sensor channel of each pair (converted first)
  function automatic logic [2:0] ch_a(input logic [1:0] p);
    case (p)
      2'd0:    ch_a = 3'd1;
      2'd1:    ch_a = 3'd4;
      default: ch_a = 3'd3;
    endcase
  endfunction

  // Left-hand sensor channel of each pair (converted second)
  function automatic logic [2:0] ch_b(input logic [1:0] p);
    case (p)
      2'd0:    ch_b = 3'd0;
      2'd1:    ch_b = 3'd2;
      default: ch_b = 3'd7;
    endcase
  endfunction

  // One-hot emitter enable for a pair: bit0 IN, bit1 MID, bit2 OUT
  function automatic logic [2:0] pair_en(input logic [1:0] p);
    case (p)
      2'd0:    pair_en = 3'b001;
      2'd1:    pair_en = 3'b010;
      default: pair_en = 3'b100;
    endcase
  endfunction

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pair       <= PAIR_IN;
      resume     <= 1'b0;
      strt_cnv   <= 1'b0;
      chnnl      <= 3'd0;
      IR_in_en   <= 1'b0;
      IR_mid_en  <= 1'b0;
      IR_out_en  <= 1'b0;
      sweep_done <= 1'b0;
      batt_gnt   <= 1'b0;
    end else begin
      state      <= state_d;
      pair       <= pair_d;
      resume     <= resume_d;
      strt_cnv   <= strt_d;
      chnnl      <= chnnl_d;
      IR_in_en   <= en_d[0];
      IR_mid_en  <= en_d[1];
      IR_out_en  <= en_d[2];
      sweep_done <= done_d;
      batt_gnt   <= lat_batt;
    end
  end

  // Settle counter: cleared on SETTLE entry, counts every SETTLE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state_d == SETTLE && state != SETTLE) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  // Result capture on the completing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_in_lft  <= '0;
      ir_in_rht  <= '0;
      ir_mid_lft <= '0;
      ir_mid_rht <= '0;
      ir_out_lft <= '0;
      ir_out_rht <= '0;
      batt_res   <= '0;
    end else begin
      if (lat_a) begin
        case (pair)
          2'd0:    ir_in_rht  <= A2D_res;
          2'd1:    ir_mid_rht <= A2D_res;
          default: ir_out_rht <= A2D_res;
        endcase
      end
      if (lat_b) begin
        case (pair)
          2'd0:    ir_in_lft  <= A2D_res;
          2'd1:    ir_mid_lft <= A2D_res;
          default: ir_out_lft <= A2D_res;
        endcase
      end
      if (lat_batt) batt_res <= A2D_res;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    pair_d   = pair;
    resume_d = resume;
    strt_d   = 1'b0;
    chnnl_d  = chnnl;
    en_d     = {IR_out_en, IR_mid_en, IR_in_en};
    done_d   = 1'b0;
    lat_a    = 1'b0;
    lat_b    = 1'b0;
    lat_batt = 1'b0;
    case (state)
      IDLE: begin
        en_d     = 3'b000;
        resume_d = 1'b0;
        if (go) begin
          state_d = SETTLE;
          pair_d  = PAIR_IN;
          en_d    = pair_en(PAIR_IN);
        end else if (batt_req) begin
          state_d = BATT_CNV;
          strt_d  = 1'b1;
          chnnl_d = BATT_CH;
        end
      end
      SETTLE: begin
        if (!go) begin
          state_d = IDLE;
          en_d    = 3'b000;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_d = CNV_A;
          strt_d  = 1'b1;
          chnnl_d = ch_a(pair);
        end
      end
      CNV_A: state_d = WAIT_A;
      WAIT_A: begin
        if (cnv_cmplt) begin
          lat_a = 1'b1;
          if (!go) begin
            state_d = IDLE;
            en_d    = 3'b000;
          end else begin
            state_d = CNV_B;
            strt_d  = 1'b1;
            chnnl_d = ch_b(pair);
          end
        end
      end
      CNV_B: state_d = WAIT_B;
      WAIT_B: begin
        if (cnv_cmplt) begin
          lat_b = 1'b1;
          en_d  = 3'b000;
          if (!go) begin
            state_d = IDLE;
          end else if (pair == PAIR_OUT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (batt_req) begin
            state_d  = BATT_CNV;
            strt_d   = 1'b1;
            chnnl_d  = BATT_CH;
            resume_d = 1'b1;
            pair_d   = 2'(pair + 2'd1);
          end else begin
            state_d = SETTLE;
            pair_d  = 2'(pair + 2'd1);
            en_d    = pair_en(2'(pair + 2'd1));
          end
        end
      end
      BATT_CNV: state_d = BATT_WAIT;
      BATT_WAIT: begin
        if (cnv_cmplt) begin
          lat_batt = 1'b1;
          resume_d = 1'b0;
          if (resume && go) begin
            state_d = SETTLE;
            en_d    = pair_en(pair);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: scoreboard bench with a 40-cycle A2D model returning 12'h100+chnnl.
module tb_a2d_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        batt_req = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] A2D_res = 12'h000;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [11:0] ir_in_lft, ir_in_rht, ir_mid_lft, ir_mid_rht, ir_out_lft, ir_out_rht;
  logic [11:0] batt_res;
  logic        batt_gnt, sweep_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_sweep = 0, n_gnt = 0, en_seen = 0, onehot_viol = 0, twice_viol = 0;
  bit stale = 0;

  logic [2:0]  chq[$];
  logic [14:0] expq[$];

  a2d_sched dut (
    .clk(clk), .rst_n(rst_n), .go(go), .batt_req(batt_req),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .IR_in_en(IR_in_en), .IR_mid_en(IR_mid_en), .IR_out_en(IR_out_en),
    .ir_in_lft(ir_in_lft), .ir_in_rht(ir_in_rht),
    .ir_mid_lft(ir_mid_lft), .ir_mid_rht(ir_mid_rht),
    .ir_out_lft(ir_out_lft), .ir_out_rht(ir_out_rht),
    .batt_res(batt_res), .batt_gnt(batt_gnt), .sweep_done(sweep_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Result register fed by a given channel
  function automatic logic [11:0] reg_of(input logic [2:0] ch);
    case (ch)
      3'd0:    reg_of = ir_in_lft;
      3'd1:    reg_of = ir_in_rht;
      3'd2:    reg_of = ir_mid_lft;
      3'd4:    reg_of = ir_mid_rht;
      3'd3:    reg_of = ir_out_rht;
      3'd7:    reg_of = ir_out_lft;
      default: reg_of = batt_res;
    endcase
  endfunction

  // A2D model and scoreboard
  initial begin
    bit          pending = 0, chk_pend = 0;
    int          cd = 0;
    logic [2:0]  pch = 3'd0, cch = 3'd0;
    logic [11:0] cval = 12'h000;
    logic [14:0] e;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (chk_pend) begin
        check($sformatf("sb_ch%0d", cch), 32'(reg_of(cch)), 32'(cval));
        chk_pend = 0;
      end
      if (strt_cnv) begin
        if (pending) twice_viol++;
        if (chq.size() == 0) check("ch_unexpected", 32'(chnnl), 32'hFF);
        else check("ch_order", 32'(chnnl), 32'(chq.pop_front()));
        expq.push_back({chnnl, 12'(12'h100 + 12'(chnnl))});
        pending = 1; pch = chnnl; cd = 40;
      end else if (pending) begin
        cd--;
        if (cd == 0) begin
          cnv_cmplt = 1'b1;
          A2D_res   = 12'(12'h100 + 12'(pch));
          pending   = 0;
          if (expq.size() != 0) begin
            e = expq.pop_front();
            cch = e[14:12];
            cval = stale ? 12'h000 : e[11:0];
            chk_pend = 1;
          end
          stale = 0;
        end
      end
    end
  end

  // Event counters and one-hot enable monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (int'(IR_in_en) + int'(IR_mid_en) + int'(IR_out_en) > 1) onehot_viol++;
        if (IR_in_en || IR_mid_en || IR_out_en) en_seen++;
        if (sweep_done) n_sweep++;
        if (batt_gnt) n_gnt++;
      end
    end
  end

  task automatic clr_counts();
    n_sweep = 0; n_gnt = 0; en_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    #5;
    check("rst_ctrl", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, batt_gnt, sweep_done}), 32'h0);
    check("rst_res", 32'({ir_in_rht, ir_out_lft}), 32'h0);
    check("rst_batt", 32'(batt_res), 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Scenario 1: full sweep, settle timing, back-to-back restart, abort in SETTLE
    clr_counts();
    chq = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    go = 1'b1;
    n = 0;
    while (!IR_in_en && n < 10) begin @(negedge clk); n++; end
    check("s1_in_en", 32'(IR_in_en), 32'h1);
    n = 1;
    while (!strt_cnv && n < 5000) begin @(negedge clk); n++; end
    check("s1_settle_len", 32'(n), 32'd4097);
    n = 0;
    while (!sweep_done && n < 20000) begin @(negedge clk); n++; end
    check("s1_done_seen", 32'(sweep_done), 32'h1);
    check("s1_in", 32'({ir_in_rht, ir_in_lft}), 32'h101100);
    check("s1_mid", 32'({ir_mid_rht, ir_mid_lft}), 32'h104102);
    check("s1_out", 32'({ir_out_rht, ir_out_lft}), 32'h103107);
    check("s1_done_en", 32'({IR_in_en, IR_mid_en, IR_out_en}), 32'h0);
    @(negedge clk);
    check("s1_restart", 32'(IR_in_en), 32'h1);
    go = 1'b0;
    @(negedge clk);
    check("s1_abort_en", 32'(IR_in_en), 32'h0);
    idle(20);
    check("s1_sweeps", 32'(n_sweep), 32'd1);
    check("s1_chq_empty", 32'(chq.size()), 32'd0);

    // Scenario 2: battery request during IN settle
    clr_counts();
    chq = '{3'd1, 3'd0, 3'd6, 3'd4, 3'd2, 3'd3, 3'd7};
    go = 1'b1;
    idle(100);
    batt_req = 1'b1;
    n = 0;
    while (!batt_gnt && n < 10000) begin @(negedge clk); n++; end
    check("s2_gnt_seen", 32'(batt_gnt), 32'h1);
    check("s2_batt_res", 32'(batt_res), 32'h106);
    check("s2_mid_en", 32'(IR_mid_en), 32'h1);
    batt_req = 1'b0;
    n = 0;
    while (!sweep_done && n < 20000) begin @(negedge clk); n++; end
    check("s2_done_seen", 32'(sweep_done), 32'h1);
    go = 1'b0;
    idle(20);
    check("s2_sweeps", 32'(n_sweep), 32'd1);
    check("s2_gnts", 32'(n_gnt), 32'd1);
    check("s2_chq_empty", 32'(chq.size()), 32'd0);

    // Scenario 3: standalone battery conversion
    clr_counts();
    chq = '{3'd6};
    batt_req = 1'b1;
    n = 0;
    while (!strt_cnv && n < 10) begin @(negedge clk); n++; end
    check("s3_strt_seen", 32'(strt_cnv), 32'h1);
    batt_req = 1'b0;
    idle(60);
    check("s3_gnts", 32'(n_gnt), 32'd1);
    check("s3_en_seen", 32'(en_seen), 32'd0);
    check("s3_chq_empty", 32'(chq.size()), 32'd0);

    // Scenario 4: go drops in WAIT_A of MID
    clr_counts();
    chq = '{3'd1, 3'd0, 3'd4};
    go = 1'b1;
    n = 0;
    while (!(strt_cnv && IR_mid_en) && n < 15000) begin @(negedge clk); n++; end
    check("s4_mid_cnv", 32'({strt_cnv, IR_mid_en}), 32'h3);
    @(negedge clk);
    go = 1'b0;
    idle(60);
    check("s4_mid_rht", 32'(ir_mid_rht), 32'h104);
    check("s4_mid_lft_hold", 32'(ir_mid_lft), 32'h102);
    check("s4_en", 32'({IR_in_en, IR_mid_en, IR_out_en}), 32'h0);
    check("s4_sweeps", 32'(n_sweep), 32'd0);
    check("s4_chq_empty", 32'(chq.size()), 32'd0);

    // Scenario 5: reset in WAIT_B of OUT, late completion ignored
    clr_counts();
    chq = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    go = 1'b1;
    n = 0;
    while (!(strt_cnv && chnnl == 3'd7) && n < 20000) begin @(negedge clk); n++; end
    check("s5_out_lft_cnv", 32'({strt_cnv, chnnl}), 32'hF);
    idle(10);
    rst_n = 1'b0;
    stale = 1;
    go = 1'b0;
    #1;
    check("s5_rst_ctrl", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, batt_gnt, sweep_done}), 32'h0);
    check("s5_rst_res", 32'({ir_in_rht, ir_out_rht}), 32'h0);
    check("s5_rst_batt", 32'(batt_res), 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(60);
    check("s5_out_lft", 32'(ir_out_lft), 32'h0);
    check("s5_en", 32'({IR_in_en, IR_mid_en, IR_out_en}), 32'h0);
    check("s5_sweeps", 32'(n_sweep), 32'd0);
    check("s5_expq_empty", 32'(expq.size()), 32'd0);

    // Properties watched across all scenarios
    check("onehot_en", 32'(onehot_viol), 32'd0);
    check("strt_twice", 32'(twice_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
